// File: rtl/dffram_mbist.sv
// March C- MBIST engine. It drives a DFFRAM single-port macro and reports pass/fail.
// Define MBIST_FAIL_LOG_EN to add first-mismatch capture outputs: fail_addr, fail_elem and fail_bits.
module dffram_mbist #(
    parameter int unsigned AW     = 9,
    parameter int unsigned DW     = 32,
    parameter int unsigned WSIZE  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WSIZE-1:0] WE0,
    output logic             EN0,
    output logic [AW-1:0]    A0,
    output logic [DW-1:0]    Di0,
    input  logic [DW-1:0]    Do0
`ifdef MBIST_FAIL_LOG_EN
    ,
    output logic [AW-1:0]    fail_addr,
    output logic [2:0]       fail_elem,
    output logic [DW-1:0]    fail_bits
`endif
);
    localparam int unsigned CW        = $clog2(RD_LAT + 1);
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    // Encoding puts the march element number in the low three bits (M1..M5 = 1..5).
    typedef enum logic [3:0] {
        S_M0    = 4'd0,
        S_M1    = 4'd1,
        S_M2    = 4'd2,
        S_M3    = 4'd3,
        S_M4    = 4'd4,
        S_M5    = 4'd5,
        S_DRAIN = 4'd6,
        S_DONE  = 4'd7,
        S_IDLE  = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic               en0_q, en0_d;
    logic [WSIZE-1:0]   we0_q, we0_d;
    logic [DW-1:0]      di0_q, di0_d;
    logic [RD_LAT-1:0]  rp_vld_q, rp_vld_d, rp_one_q, rp_one_d;
    logic               is_op_c, mism_c, accept_c;

    assign accept_c = start && (state_q == S_IDLE || state_q == S_DONE);
    assign mism_c   = rp_vld_q[RD_LAT-1] && (Do0 != {DW{rp_one_q[RD_LAT-1]}});

    // State and address registers always describe the op currently on the RAM port.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q | mism_c;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_M0;
                    addr_d  = '0;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_M1;
                    addr_d  = '0;
                    wr_d    = 1'b0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_M1, S_M2: begin
                wr_d = !wr_q;
                if (wr_q) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = (state_q == S_M1) ? S_M2 : S_M3;
                        addr_d  = (state_q == S_M1) ? '0 : ADDR_LAST;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_M3, S_M4: begin
                wr_d = !wr_q;
                if (wr_q) begin
                    if (addr_q == '0) begin
                        state_d = (state_q == S_M3) ? S_M4 : S_M5;
                        addr_d  = (state_q == S_M3) ? ADDR_LAST : '0;
                    end else begin
                        addr_d = addr_q - AW'(1);
                    end
                end
            end
            S_M5: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !(fail_q || mism_c);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        is_op_c = (state_d inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5});
        en0_d   = is_op_c;
        we0_d   = (is_op_c && wr_d) ? '1 : '0;
        di0_d   = (is_op_c && wr_d && (state_d == S_M1 || state_d == S_M3)) ? '1 : '0;

        // Read-compare pipeline: stage 0 is loaded from the op on the port this cycle.
        rp_vld_d    = rp_vld_q;
        rp_one_d    = rp_one_q;
        rp_vld_d[0] = en0_q && !wr_q;
        rp_one_d[0] = (state_q == S_M2) || (state_q == S_M4);
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rp_vld_d[i] = rp_vld_q[i-1];
            rp_one_d[i] = rp_one_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            en0_q    <= 1'b0;
            we0_q    <= '0;
            di0_q    <= '0;
            rp_vld_q <= '0;
            rp_one_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            en0_q    <= en0_d;
            we0_q    <= we0_d;
            di0_q    <= di0_d;
            rp_vld_q <= rp_vld_d;
            rp_one_q <= rp_one_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;
    assign EN0  = en0_q;
    assign WE0  = we0_q;
    assign A0   = addr_q;
    assign Di0  = di0_q;

`ifdef MBIST_FAIL_LOG_EN
    logic [AW-1:0] rp_addr_q [RD_LAT];
    logic [AW-1:0] rp_addr_d [RD_LAT];
    logic [2:0]    rp_elem_q [RD_LAT];
    logic [2:0]    rp_elem_d [RD_LAT];
    logic [AW-1:0] faddr_q, faddr_d;
    logic [2:0]    felem_q, felem_d;
    logic [DW-1:0] fbits_q, fbits_d;

    // Address and element travel alongside the compare pipeline; only the first mismatch is logged.
    always_comb begin
        rp_addr_d    = rp_addr_q;
        rp_elem_d    = rp_elem_q;
        rp_addr_d[0] = addr_q;
        rp_elem_d[0] = state_q[2:0];
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rp_addr_d[i] = rp_addr_q[i-1];
            rp_elem_d[i] = rp_elem_q[i-1];
        end
        faddr_d = faddr_q;
        felem_d = felem_q;
        fbits_d = fbits_q;
        if (accept_c) begin
            faddr_d = '0;
            felem_d = '0;
            fbits_d = '0;
        end else if (mism_c && !fail_q) begin
            faddr_d = rp_addr_q[RD_LAT-1];
            felem_d = rp_elem_q[RD_LAT-1];
            fbits_d = Do0 ^ {DW{rp_one_q[RD_LAT-1]}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                rp_addr_q[i] <= '0;
                rp_elem_q[i] <= '0;
            end
            faddr_q <= '0;
            felem_q <= '0;
            fbits_q <= '0;
        end else begin
            rp_addr_q <= rp_addr_d;
            rp_elem_q <= rp_elem_d;
            faddr_q   <= faddr_d;
            felem_q   <= felem_d;
            fbits_q   <= fbits_d;
        end
    end

    assign fail_addr = faddr_q;
    assign fail_elem = felem_q;
    assign fail_bits = fbits_q;
`endif
endmodule

// File: tb/tb_dffram_mbist.sv
// Bench for dffram_mbist: two engines (RD_LAT=1 and RD_LAT=2) share stimulus, each with its own RAM model.
module tb_dffram_mbist;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned WSIZE = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int          OPS   = 10 * DEPTH;

    typedef struct {
        int            done_cyc;
        bit            pass;
        int            en_cnt;
        logic [AW-1:0] faddr;
        logic [2:0]    felem;
        logic [DW-1:0] fbits;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic start = 1'b0;

    logic             busy_w [2];
    logic             done_w [2];
    logic             pass_w [2];
    logic             en_w   [2];
    logic [WSIZE-1:0] we_w   [2];
    logic [AW-1:0]    a_w    [2];
    logic [DW-1:0]    di_w   [2];
    logic [DW-1:0]    do_w   [2];
`ifdef MBIST_FAIL_LOG_EN
    logic [AW-1:0]    faddr_w [2];
    logic [2:0]       felem_w [2];
    logic [DW-1:0]    fbits_w [2];
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   fault  = 0;
    int   en_cnt [2];
    bit   seen   [2];
    logic done_prev [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dffram_mbist #(.AW(AW), .DW(DW), .WSIZE(WSIZE), .RD_LAT(g + 1)) u_dut (
            .CLK   (CLK),
            .RST   (RST),
            .start (start),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .pass  (pass_w[g]),
            .WE0   (we_w[g]),
            .EN0   (en_w[g]),
            .A0    (a_w[g]),
            .Di0   (di_w[g]),
            .Do0   (do_w[g])
`ifdef MBIST_FAIL_LOG_EN
            ,
            .fail_addr (faddr_w[g]),
            .fail_elem (felem_w[g]),
            .fail_bits (fbits_w[g])
`endif
        );
    end

    // RAM models; fault 1 = bit 5 stuck-at-1 at 0x3, fault 2 = writes to 0xF also land in 0x7.
    logic [DW-1:0] mem [2][DEPTH];
    logic [DW-1:0] rd_s1 [2];
    logic [DW-1:0] rd_s2;

    function automatic logic [DW-1:0] rd_word(input int d, input logic [AW-1:0] a);
        logic [DW-1:0] w = mem[d][a];
        if (fault == 1 && a == AW'(3)) w = w | 32'h0000_0020;
        return w;
    endfunction

    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (en_w[d] && we_w[d] == '0) rd_s1[d] <= rd_word(d, a_w[d]);
            if (en_w[d] && we_w[d] != '0) begin
                mem[d][a_w[d]] <= di_w[d];
                if (fault == 2 && a_w[d] == AW'(15)) mem[d][7] <= di_w[d];
            end
        end
        rd_s2 <= rd_s1[1];
    end
    assign do_w[0] = rd_s1[0];
    assign do_w[1] = rd_s2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t sb_pop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Scoreboard consumer: compares each completed test against the record pushed at start.
    always @(negedge CLK) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (en_w[d]) en_cnt[d]++;
            if (done_w[d] && !done_prev[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    chk($sformatf("unexpected_done%0d", d), 64'(1), 64'(0));
                end else begin
                    e = sb_pop(d);
                    chk($sformatf("done_cycle%0d", d), 64'(cyc), 64'(e.done_cyc));
                    chk($sformatf("pass%0d", d), 64'(pass_w[d]), 64'(e.pass));
                    chk($sformatf("en_cycles%0d", d), 64'(en_cnt[d]), 64'(e.en_cnt));
                    chk($sformatf("busy_at_done%0d", d), 64'(busy_w[d]), 64'(0));
`ifdef MBIST_FAIL_LOG_EN
                    chk($sformatf("fail_addr%0d", d), 64'(faddr_w[d]), 64'(e.faddr));
                    chk($sformatf("fail_elem%0d", d), 64'(felem_w[d]), 64'(e.felem));
                    chk($sformatf("fail_bits%0d", d), 64'(fbits_w[d]), 64'(e.fbits));
`endif
                end
                seen[d] = 1'b1;
            end
            done_prev[d] = done_w[d];
        end
    end

    task automatic do_start(input bit p, input logic [AW-1:0] fa, input logic [2:0] fe,
                            input logic [DW-1:0] fb);
        exp_t e;
        @(negedge CLK);
        #1;
        start = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en_cnt[d]  = 0;
            seen[d]    = 1'b0;
            e.done_cyc = cyc + 1 + OPS + d + 1;
            e.pass     = p;
            e.en_cnt   = OPS;
            e.faddr    = p ? '0 : fa;
            e.felem    = p ? '0 : fe;
            e.fbits    = p ? '0 : fb;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy_after_start%0d", d), 64'(busy_w[d]), 64'(1));
            chk($sformatf("done_after_start%0d", d), 64'(done_w[d]), 64'(0));
        end
        #1 start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        #1 start = 1'b1;
        @(negedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(seen[0] && seen[1]) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("done_within_budget", 64'(seen[0] && seen[1]), 64'(1));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            en_cnt[d]    = 0;
            seen[d]      = 1'b0;
            done_prev[d] = 1'b0;
        end
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy%0d", d), 64'(busy_w[d]), 64'(0));
            chk($sformatf("rst_done%0d", d), 64'(done_w[d]), 64'(0));
            chk($sformatf("rst_pass%0d", d), 64'(pass_w[d]), 64'(0));
            chk($sformatf("rst_en0_%0d", d), 64'(en_w[d]), 64'(0));
            chk($sformatf("rst_we0_%0d", d), 64'(we_w[d]), 64'(0));
            chk($sformatf("rst_a0_%0d", d), 64'(a_w[d]), 64'(0));
            chk($sformatf("rst_di0_%0d", d), 64'(di_w[d]), 64'(0));
        end
        #1 RST = 1'b0;
        repeat (5) @(negedge CLK);

        fault = 0;
        do_start(1'b1, '0, '0, '0);
        wait_done(400);

        fault = 1;
        do_start(1'b0, AW'(3), 3'd1, 32'h0000_0020);
        wait_done(400);

        fault = 2;
        do_start(1'b0, AW'(7), 3'd3, 32'hFFFF_FFFF);
        wait_done(400);

        // Reset in the middle of M2 aborts both engines.
        fault = 0;
        do_start(1'b1, '0, '0, '0);
        repeat (59) @(negedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort_en0_%0d", d), 64'(en_w[d]), 64'(0));
            chk($sformatf("abort_we0_%0d", d), 64'(we_w[d]), 64'(0));
            chk($sformatf("abort_busy%0d", d), 64'(busy_w[d]), 64'(0));
            chk($sformatf("abort_done%0d", d), 64'(done_w[d]), 64'(0));
        end
        q0.delete();
        q1.delete();
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        do_start(1'b1, '0, '0, '0);
        wait_done(400);

        // Extra start pulses while busy must not disturb the run.
        do_start(1'b1, '0, '0, '0);
        repeat (20) @(negedge CLK);
        pulse_start();
        repeat (60) @(negedge CLK);
        pulse_start();
        wait_done(400);

        // Start while in DONE reruns the whole test.
        do_start(1'b1, '0, '0, '0);
        wait_done(400);

        chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
